// File: rtl/dpram_pkg.sv
// Shared constants for the parameterised dual-port RAM: read-during-write
// encodings and the legal read-latency range.
package dpram_pkg;

  // Cross-port read-during-write result selection.
  typedef enum int unsigned {
    OLD_DATA = 0,
    NEW_DATA = 1
  } rdw_mode_e;

  localparam int unsigned RD_LATENCY_MIN = 1;
  localparam int unsigned RD_LATENCY_MAX = 2;

  function automatic bit rd_latency_legal(input int unsigned lat);
    return (lat >= RD_LATENCY_MIN) && (lat <= RD_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/dpram_rd_pipe.sv
// Per-port read pipeline: zeroes out-of-range words, delays the read by
// RD_LATENCY cycles, produces the valid pulse and holds the last output.
module dpram_rd_pipe
  import dpram_pkg::*;
#(
  parameter int DWIDTH     = 40,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              issue,
  input  logic              zero,
  input  logic [DWIDTH-1:0] rd_word,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_valid
);

  logic [DWIDTH-1:0] word_masked;
  logic              s1_valid;
  logic [DWIDTH-1:0] s1_word;

  // Out-of-range reads still complete, but always return zero.
  assign word_masked = zero ? '0 : rd_word;

  if (RD_LATENCY == 2) begin : g_lat2
    // Extra stage for two-cycle latency; a new read can enter every cycle.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        s1_valid <= 1'b0;
        s1_word  <= '0;
      end else begin
        s1_valid <= issue;
        if (issue) s1_word <= word_masked;
      end
    end
  end else begin : g_lat1
    assign s1_valid = issue;
    assign s1_word  = word_masked;
  end

  // Output stage: pulse valid on completion, otherwise hold the last word.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= s1_valid;
      if (s1_valid) rd_data <= s1_word;
    end
  end

endmodule

// File: rtl/dpram_param.sv
// True dual-port RAM with lane write enables, configurable read latency,
// selectable cross-port read-during-write behaviour, and collision /
// out-of-range status pulses.
module dpram_param
  import dpram_pkg::*;
#(
  parameter int AWIDTH     = 11,
  parameter int NUM_WORDS  = 2048,
  parameter int DWIDTH     = 40,
  parameter int NUM_LANES  = 5,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [AWIDTH-1:0]    address_a,
  input  logic [AWIDTH-1:0]    address_b,
  input  logic                 wren_a,
  input  logic                 wren_b,
  input  logic                 rden_a,
  input  logic                 rden_b,
  input  logic [NUM_LANES-1:0] be_a,
  input  logic [NUM_LANES-1:0] be_b,
  input  logic [DWIDTH-1:0]    data_a,
  input  logic [DWIDTH-1:0]    data_b,
  output logic [DWIDTH-1:0]    out_a,
  output logic [DWIDTH-1:0]    out_b,
  output logic                 valid_a,
  output logic                 valid_b,
  output logic                 collision,
  output logic                 oob
);

  localparam int                LANE_W = DWIDTH / NUM_LANES;
  localparam logic [AWIDTH:0]   DEPTH  = (AWIDTH + 1)'(NUM_WORDS);
  localparam bit                BYPASS = (RDW_MODE == int'(NEW_DATA));

  if (!rd_latency_legal(RD_LATENCY)) begin : g_bad_latency
    $error("dpram_param: RD_LATENCY must be 1 or 2");
  end
  if ((DWIDTH % NUM_LANES) != 0) begin : g_bad_lanes
    $error("dpram_param: DWIDTH must be a multiple of NUM_LANES");
  end

  logic [DWIDTH-1:0] mem [NUM_WORDS];

  logic              in_range_a, in_range_b;
  logic              wr_a, wr_b;
  logic              issue_a, issue_b;
  logic [DWIDTH-1:0] rd_word_a, rd_word_b;

  // Nothing is accepted while reset is asserted.
  assign in_range_a = {1'b0, address_a} < DEPTH;
  assign in_range_b = {1'b0, address_b} < DEPTH;
  assign wr_a       = resetn && wren_a && in_range_a;
  assign wr_b       = resetn && wren_b && in_range_b;
  assign issue_a    = resetn && rden_a && !wren_a;
  assign issue_b    = resetn && rden_b && !wren_b;

  // Lane-masked writes; port B is applied first so port A overrides any
  // lane both ports enable on the same address.
  // NOTE: the storage array has no reset so it maps onto block RAM; its
  // contents survive resetn.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (wr_b && be_b[i]) mem[address_b][i*LANE_W +: LANE_W] <= data_b[i*LANE_W +: LANE_W];
      if (wr_a && be_a[i]) mem[address_a][i*LANE_W +: LANE_W] <= data_a[i*LANE_W +: LANE_W];
    end
  end

  // Read word per port, optionally merged with the other port's same-cycle
  // write to the same address.
  // NOTE: combinational logic uses blocking assignments, and every output is
  // given a default first so no latch is inferred.
  always_comb begin
    rd_word_a = mem[address_a];
    rd_word_b = mem[address_b];
    if (BYPASS) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wr_b && (address_b == address_a) && be_b[i])
          rd_word_a[i*LANE_W +: LANE_W] = data_b[i*LANE_W +: LANE_W];
        if (wr_a && (address_a == address_b) && be_a[i])
          rd_word_b[i*LANE_W +: LANE_W] = data_a[i*LANE_W +: LANE_W];
      end
    end
  end

  // Status pulses, one cycle after the offending access.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      collision <= 1'b0;
      oob       <= 1'b0;
    end else begin
      collision <= wren_a && wren_b && (address_a == address_b);
      oob       <= ((wren_a || rden_a) && !in_range_a) ||
                   ((wren_b || rden_b) && !in_range_b);
    end
  end

  dpram_rd_pipe #(
    .DWIDTH     (DWIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_pipe_a (
    .clk      (clk),
    .resetn   (resetn),
    .issue    (issue_a),
    .zero     (!in_range_a),
    .rd_word  (rd_word_a),
    .rd_data  (out_a),
    .rd_valid (valid_a)
  );

  dpram_rd_pipe #(
    .DWIDTH     (DWIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_pipe_b (
    .clk      (clk),
    .resetn   (resetn),
    .issue    (issue_b),
    .zero     (!in_range_b),
    .rd_word  (rd_word_b),
    .rd_data  (out_b),
    .rd_valid (valid_b)
  );

endmodule
